// File: rtl/unified_memory_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
// FSM state and transaction-owner codes used by the top and grant logic.
package unified_memory_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;

endpackage

// File: rtl/unified_memory_arbiter_grant_select.sv
// Combinational two-requester grant for the unified memory arbiter.
// ARBITER_ROUND_ROBIN_EN selects alternating priority; default is data first.
module arbiter_grant_select
  import unified_memory_arbiter_pkg::*;
(
  input  logic       i_fetch_req,
  input  logic       i_data_req,
  input  logic [1:0] i_last_owner,
  input  logic       i_idle,
  output logic       o_grant_fetch,
  output logic       o_grant_data
);

  logic w_fetch_wins;

`ifdef ARBITER_ROUND_ROBIN_EN
  // On contention fetch wins only if data won last time.
  assign w_fetch_wins = ~i_data_req | (i_last_owner == OWN_DATA);
`else
  logic w_unused;
  assign w_unused = ^i_last_owner;
  // Fixed priority: fetch wins only when data is silent.
  assign w_fetch_wins = ~i_data_req;
`endif

  assign o_grant_fetch = i_idle & i_fetch_req & w_fetch_wins;
  assign o_grant_data  = i_idle & i_data_req & ~(i_fetch_req & w_fetch_wins);

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Optional macro ARBITER_ROUND_ROBIN_EN enables alternating grant priority.
module unified_memory_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int NUM_BYTES    = DATA_WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_read,
  input  logic [ADDRESS_BITS-1:0] fetch_address,
  output logic                    fetch_ready,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_data_out,
  output logic [ADDRESS_BITS-1:0] fetch_address_out,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [NUM_BYTES-1:0]    data_byte_en,
  input  logic [ADDRESS_BITS-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_ready,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic [ADDRESS_BITS-1:0] data_address_out,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [NUM_BYTES-1:0]    mem_byte_en,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic [ADDRESS_BITS-1:0] mem_address_in
);

  logic [1:0]              r_state;
  logic [1:0]              r_owner;
  logic                    r_read;
  logic                    r_write;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [NUM_BYTES-1:0]    r_be;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_fetch_valid;
  logic                    r_data_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic [ADDRESS_BITS-1:0] r_resp_addr;

  logic       w_idle;
  logic       w_data_req;
  logic       w_grant_fetch;
  logic       w_grant_data;
  logic [1:0] w_last_owner;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_data_req = data_read | data_write;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [1:0] r_last_owner;

  // Remember who won the most recent grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_owner <= OWN_FETCH;
    end else if (w_grant_data) begin
      r_last_owner <= OWN_DATA;
    end else if (w_grant_fetch) begin
      r_last_owner <= OWN_FETCH;
    end
  end

  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWN_NONE;
`endif

  arbiter_grant_select u_grant (
    .i_fetch_req  (fetch_read),
    .i_data_req   (w_data_req),
    .i_last_owner (w_last_owner),
    .i_idle       (w_idle),
    .o_grant_fetch(w_grant_fetch),
    .o_grant_data (w_grant_data)
  );

  // Latch the granted request, hold it until accepted, route the reply.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_NONE;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_be          <= '0;
      r_wdata       <= '0;
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_addr   <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_data) begin
            r_read  <= data_read & ~data_write;
            r_write <= data_write;
            r_addr  <= data_address;
            r_be    <= data_byte_en;
            r_wdata <= data_wdata;
            r_owner <= OWN_DATA;
            r_state <= ST_ISSUE;
          end else if (w_grant_fetch) begin
            r_read  <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= fetch_address;
            r_be    <= '1;
            r_wdata <= '0;
            r_owner <= OWN_FETCH;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_write) begin
              r_owner <= OWN_NONE;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_RESP;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (mem_valid && (mem_address_in == r_addr)) begin
            r_fetch_valid <= (r_owner == OWN_FETCH);
            r_data_valid  <= (r_owner == OWN_DATA);
            r_resp_data   <= mem_rdata;
            r_resp_addr   <= r_addr;
            r_owner       <= OWN_NONE;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fetch_ready       = w_grant_fetch;
  assign data_ready        = w_grant_data;
  assign fetch_valid       = r_fetch_valid;
  assign data_valid        = r_data_valid;
  assign fetch_data_out    = r_resp_data;
  assign data_rdata        = r_resp_data;
  assign fetch_address_out = r_resp_addr;
  assign data_address_out  = r_resp_addr;
  assign mem_read          = r_read;
  assign mem_write         = r_write;
  assign mem_byte_en       = r_be;
  assign mem_address       = r_addr;
  assign mem_wdata         = r_wdata;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Scoreboard bench for unified_memory_arbiter.
// Directed stimulus; a negedge monitor checks every response pulse.
module tb_unified_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_read;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data_out;
  logic [31:0] fetch_address_out;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byte_en;
  logic [31:0] data_address;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic [31:0] data_address_out;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] mem_address_in;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  exp_t        mon_e;
  logic [31:0] mon_d;
  logic [31:0] mon_a;

  always #5 clock = ~clock;

  unified_memory_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_read       (fetch_read),
    .fetch_address    (fetch_address),
    .fetch_ready      (fetch_ready),
    .fetch_valid      (fetch_valid),
    .fetch_data_out   (fetch_data_out),
    .fetch_address_out(fetch_address_out),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_byte_en     (data_byte_en),
    .data_address     (data_address),
    .data_wdata       (data_wdata),
    .data_ready       (data_ready),
    .data_valid       (data_valid),
    .data_rdata       (data_rdata),
    .data_address_out (data_address_out),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_en      (mem_byte_en),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_ready        (mem_ready),
    .mem_valid        (mem_valid),
    .mem_rdata        (mem_rdata),
    .mem_address_in   (mem_address_in)
  );

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && (fetch_valid || data_valid)) begin
      checks++;
      if (fetch_valid && data_valid) begin
        errors++;
        $display("FAIL resp_both: fetch_valid=1 data_valid=1, required one");
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: fv=%0b dv=%0b, required none",
                 fetch_valid, data_valid);
      end else begin
        mon_e = q.pop_front();
        mon_d = data_valid ? data_rdata : fetch_data_out;
        mon_a = data_valid ? data_address_out : fetch_address_out;
        if (data_valid !== mon_e.is_data || mon_d !== mon_e.data ||
            mon_a !== mon_e.addr) begin
          errors++;
          $display("FAIL resp: is_data=%0b d=%h a=%h, required %0b %h %h",
                   data_valid, mon_d, mon_a,
                   mon_e.is_data, mon_e.data, mon_e.addr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic d, input logic [31:0] dat,
                      input logic [31:0] a);
    exp_t e;
    e.is_data = d;
    e.data    = dat;
    e.addr    = a;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d responses pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  function automatic logic any_out();
    return |{fetch_ready, fetch_valid, fetch_data_out, fetch_address_out,
             data_ready, data_valid, data_rdata, data_address_out,
             mem_read, mem_write, mem_byte_en, mem_address, mem_wdata};
  endfunction

  initial begin
    reset          = 1'b1;
    fetch_read     = 1'b0;
    fetch_address  = '0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_byte_en   = '0;
    data_address   = '0;
    data_wdata     = '0;
    mem_ready      = 1'b0;
    mem_valid      = 1'b0;
    mem_rdata      = '0;
    mem_address_in = '0;
    #3;
    chk("reset_outputs", any_out(), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Lone fetch read of 0x100.
    fetch_read    = 1'b1;
    fetch_address = 32'h100;
    mem_ready     = 1'b1;
    push(1'b0, 32'hDEADBEEF, 32'h100);
    @(negedge clock);
    chk("t1_fetch_ready", fetch_ready, 1);
    chk("t1_data_ready", data_ready, 0);
    step();
    fetch_read = 1'b0;
    @(negedge clock);
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_address, 32'h100);
    step();
    @(negedge clock);
    chk("t1_mem_read_drop", mem_read, 0);
    step();
    mem_valid      = 1'b1;
    mem_rdata      = 32'hDEADBEEF;
    mem_address_in = 32'h100;
    step();
    mem_valid = 1'b0;
    wait_drain("t1_drain");
    step();

    // Fetch 0x200 and load 0x300 together: data first, fetch next.
    fetch_read    = 1'b1;
    fetch_address = 32'h200;
    data_read     = 1'b1;
    data_address  = 32'h300;
    push(1'b1, 32'hA5A50300, 32'h300);
    push(1'b0, 32'h0F0F0200, 32'h200);
    @(negedge clock);
    chk("t2_data_ready", data_ready, 1);
    chk("t2_fetch_ready", fetch_ready, 0);
    step();
    data_read = 1'b0;
    @(negedge clock);
    chk("t2_mem_addr_load", mem_address, 32'h300);
    chk("t2_fetch_blocked", fetch_ready, 0);
    step();
    mem_valid      = 1'b1;
    mem_rdata      = 32'hA5A50300;
    mem_address_in = 32'h300;
    step();
    mem_valid = 1'b0;
    @(negedge clock);
    chk("t2_fetch_regrant", fetch_ready, 1);
    step();
    fetch_read = 1'b0;
    @(negedge clock);
    chk("t2_mem_addr_fetch", mem_address, 32'h200);
    step();
    mem_valid      = 1'b1;
    mem_rdata      = 32'h0F0F0200;
    mem_address_in = 32'h200;
    step();
    mem_valid = 1'b0;
    wait_drain("t2_drain");
    step();

    // Store 0x400 with mem_ready low for three cycles.
    data_write   = 1'b1;
    data_address = 32'h400;
    data_byte_en = 4'b0011;
    data_wdata   = 32'h1234;
    mem_ready    = 1'b0;
    @(negedge clock);
    chk("t3_data_ready", data_ready, 1);
    step();
    data_write   = 1'b0;
    data_byte_en = 4'b0000;
    data_wdata   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      @(negedge clock);
      chk("t3_mem_write", {mem_write, mem_read}, 2'b10);
      chk("t3_payload", {mem_byte_en, mem_wdata}, {4'b0011, 32'h1234});
      chk("t3_addr", mem_address, 32'h400);
      step();
    end

    // Idle right after acceptance: load 0x500 granted at once.
    data_read    = 1'b1;
    data_address = 32'h500;
    push(1'b1, 32'h50055005, 32'h500);
    @(negedge clock);
    chk("t3_write_drop", mem_write, 0);
    chk("t4_data_ready", data_ready, 1);
    step();
    data_read = 1'b0;
    step();
    mem_valid      = 1'b1;
    mem_rdata      = 32'h0BADBAD0;
    mem_address_in = 32'h504;
    step();
    mem_rdata      = 32'h50055005;
    mem_address_in = 32'h500;
    @(negedge clock);
    chk("t4_mismatch_ignored", data_valid, 0);
    step();
    mem_valid = 1'b0;
    wait_drain("t4_drain");
    step();

    // Reset while waiting for a read response.
    data_read    = 1'b1;
    data_address = 32'h600;
    step();
    data_read = 1'b0;
    step();
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async_reset", any_out(), 0);
    step();
    reset          = 1'b0;
    mem_valid      = 1'b1;
    mem_rdata      = 32'h66;
    mem_address_in = 32'h600;
    step();
    mem_valid = 1'b0;
    @(negedge clock);
    chk("t5_late_valid", {fetch_valid, data_valid}, 0);
    step();

    // Both requesters held; grant order depends on the build.
    fetch_read    = 1'b1;
    fetch_address = 32'h700;
    data_read     = 1'b1;
    data_address  = 32'h800;
    mem_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic        exp_d;
      logic [31:0] a;
`ifdef ARBITER_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      a = exp_d ? 32'h800 : 32'h700;
      push(exp_d, 32'hC0000000 + i, a);
      @(negedge clock);
      chk("t6_data_ready", data_ready, exp_d);
      chk("t6_fetch_ready", fetch_ready, !exp_d);
      step();
      step();
      mem_valid      = 1'b1;
      mem_rdata      = 32'hC0000000 + i;
      mem_address_in = a;
      step();
      mem_valid = 1'b0;
    end
    fetch_read = 1'b0;
    data_read  = 1'b0;
    wait_drain("t6_drain");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its load/store requester. Lets a single-cycle or pipelined core run against a unified instruction/data memory.
- Sits between the core's fetch/memory interfaces and the memory or cache.
- Registers each granted request, holds it until the memory accepts it, and waits for the read response. Routes the response back to the owning requester.
- One transaction in flight at a time.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDRESS_BITS, 32, address width in bits.
- NUM_BYTES, DATA_WIDTH/8, byte-enable width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_read  in  1  fetch read request.
- fetch_address  in  ADDRESS_BITS  fetch address.
- fetch_ready  out  1  fetch request accepted this cycle.
- fetch_valid  out  1  fetch response valid, one-cycle pulse.
- fetch_data_out  out  DATA_WIDTH  fetch response data.
- fetch_address_out  out  ADDRESS_BITS  fetch response address.
- data_read  in  1  load request.
- data_write  in  1  store request.
- data_byte_en  in  NUM_BYTES  store byte enables.
- data_address  in  ADDRESS_BITS  load/store address.
- data_wdata  in  DATA_WIDTH  store data.
- data_ready  out  1  load/store request accepted this cycle.
- data_valid  out  1  load response valid, one-cycle pulse.
- data_rdata  out  DATA_WIDTH  load response data.
- data_address_out  out  ADDRESS_BITS  load response address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_byte_en  out  NUM_BYTES  memory byte enables.
- mem_address  out  ADDRESS_BITS  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ready  in  1  memory accepts the presented request.
- mem_valid  in  1  memory read response valid.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_address_in  in  ADDRESS_BITS  address tag of the response.

Behaviour:
- Reset: all outputs 0, state IDLE, owner NONE. Asserting reset mid-transaction drops the transaction; a late mem_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE, grant (default fixed priority): data beats fetch.
  - fetch_ready = fetch_read & ~(data_read | data_write) in IDLE; else 0.
  - data_ready = (data_read | data_write) in IDLE; else 0.
  - On grant: latch read/write, address, byte_en, wdata and owner; go to ISSUE.
  - A data request with both read and write set is treated as a write.
- ISSUE:
  - mem_read/mem_write and the payload are driven from registers, stable until mem_ready.
  - mem_ready & write: deassert the request next cycle, go to IDLE. Stores produce no response.
  - mem_ready & read: deassert the request, go to WAIT_RESP.
- WAIT_RESP:
  - mem_valid & (mem_address_in == latched address): pulse the owner's valid for one cycle with mem_rdata and the address; go to IDLE.
  - A mismatching address or a mem_valid in any other state is ignored.
- Latency:
  - Request to mem_* asserted: 1 cycle.
  - mem_valid to requester valid: 1 cycle (registered).
  - Minimum read round trip: 3 cycles plus memory latency.
- Back-to-back: a new grant can occur in the IDLE cycle that follows a response. No combinational path from mem_valid to any *_ready.
- Starvation: under fixed priority, fetch may starve while data requests are continuous. This is acceptable because the core stalls fetch during memory operations.

Optional Feature:
- Macro: ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A last_owner register (reset FETCH) selects the winner when both requesters are active: the requester that did not win last time wins.
  - The priority expressions for fetch_ready and data_ready follow this selection.
- Undefined: fixed data-over-fetch priority as above. The last_owner register is not built.

Decomposition:
- Package unified_memory_arbiter_pkg:
  - State encodings ST_IDLE, ST_ISSUE, ST_WAIT_RESP (2 bits).
  - Owner encodings OWN_NONE, OWN_FETCH, OWN_DATA (2 bits).
- Sub-module arbiter_grant_select: combinational two-requester grant. Inputs are both request flags, last_owner and idle; outputs are grant_fetch and grant_data. It is instantiated once and carries the macro-dependent logic.

Test Plan:
- Fetch read 0x100 alone, mem_ready=1, mem_valid 2 cycles later with 0xDEADBEEF/0x100 -> fetch_valid pulses once with 0xDEADBEEF, address 0x100; data_valid stays 0.
- Simultaneous fetch 0x200 and load 0x300 -> data_ready=1, fetch_ready=0, mem_address=0x300; fetch is granted on the next IDLE (default build).
- Store 0x400, byte_en 0b0011, wdata 0x1234, mem_ready held low 3 cycles -> mem_write and payload stable for all 4 cycles; IDLE the cycle after acceptance; no valid pulse.
- Read 0x500 in WAIT_RESP, mem_valid with mem_address_in=0x504 then with 0x500 -> first response ignored; only the second yields data_valid.
- Reset asserted in WAIT_RESP, then mem_valid -> all outputs 0 asynchronously; no valid pulse after reset release.
- ARBITER_ROUND_ROBIN_EN build, both requesters asserted continuously -> grants alternate data, fetch, data, fetch (first grant data, since last_owner resets to FETCH).
